// File: rtl/polyphase_halfband_interpolator.sv
// rtl/polyphase_halfband_interpolator.sv - upsample-by-2 halfband FIR interpolator with one shared pre-add/MAC
module polyphase_halfband_interpolator #(
    parameter int SAMPLE_WIDTH = 6,
    parameter int COEF_WIDTH   = 16,
    parameter int HALF_TAPS    = 4,
    parameter int COEF_SHIFT   = 14,
    parameter logic signed [COEF_WIDTH-1:0] COEFS [0:HALF_TAPS-1] =
        '{-16'sd160, 16'sd640, -16'sd2048, 16'sd9760}
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    input  logic signed [SAMPLE_WIDTH-1:0] data_in,
    output logic                           in_ready,
    output logic                           valid_out,
    output logic signed [SAMPLE_WIDTH-1:0] data_out
);

    localparam int TAPS   = 2 * HALF_TAPS;
    localparam int PRE_W  = SAMPLE_WIDTH + 1;
    localparam int PROD_W = SAMPLE_WIDTH + COEF_WIDTH + 1;
    localparam int ACC_W  = PROD_W + $clog2(HALF_TAPS) + 1;
    localparam int K_W    = (HALF_TAPS > 1) ? $clog2(HALF_TAPS) : 1;
    localparam int IDX_W  = $clog2(TAPS);

    // Rounding bias and clip limits, all in accumulator width so comparisons stay signed.
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (COEF_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MAC    = 2'd1,
        S_EMIT_A = 2'd2,
        S_EMIT_B = 2'd3
    } state_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic signed [SAMPLE_WIDTH-1:0]   r_dly [0:TAPS-1];
    logic signed [SAMPLE_WIDTH-1:0]   r_pass;
    logic signed [ACC_W-1:0]          r_acc;
    logic        [K_W-1:0]            r_k;
    logic                             r_valid_out;
    logic signed [SAMPLE_WIDTH-1:0]   r_data_out;

    logic                             w_accept;
    logic                             w_last_k;
    logic        [IDX_W-1:0]          w_idx_lo;
    logic        [IDX_W-1:0]          w_idx_hi;
    logic signed [PRE_W-1:0]          w_pre;
    logic signed [PROD_W-1:0]         w_prod;
    logic signed [ACC_W-1:0]          w_round;
    logic signed [ACC_W-1:0]          w_shift;
    logic signed [SAMPLE_WIDTH-1:0]   w_filt;
    logic                             w_valid_nxt;
    logic signed [SAMPLE_WIDTH-1:0]   w_data_nxt;

    assign in_ready  = (r_state == S_IDLE);
    assign w_accept  = valid_in && in_ready;
    assign w_last_k  = (r_k == K_W'(HALF_TAPS - 1));
    assign valid_out = r_valid_out;
    assign data_out  = r_data_out;

    // Pair k combines the k-th newest and k-th oldest taps, which share a coefficient.
    assign w_idx_lo = IDX_W'(r_k);
    assign w_idx_hi = IDX_W'(TAPS - 1) - w_idx_lo;
    assign w_pre    = PRE_W'(r_dly[w_idx_lo]) + PRE_W'(r_dly[w_idx_hi]);
    assign w_prod   = PROD_W'(w_pre) * PROD_W'(COEFS[r_k]);

    // Round half-up, drop fraction bits arithmetically, then clip to the sample range.
    assign w_round = r_acc + ROUND_BIAS;
    assign w_shift = w_round >>> COEF_SHIFT;

    // Saturate the scaled accumulator into the output sample width.
    always_comb begin
        w_filt = SAMPLE_WIDTH'(w_shift);
        if (w_shift > SAT_MAX) begin
            w_filt = SAMPLE_WIDTH'(SAT_MAX);
        end else if (w_shift < SAT_MIN) begin
            w_filt = SAMPLE_WIDTH'(SAT_MIN);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept, H MAC cycles, then the pass-through and filtered emits.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_MAC;
            S_MAC:    if (w_last_k) w_state_nxt = S_EMIT_A;
            S_EMIT_A: w_state_nxt = S_EMIT_B;
            S_EMIT_B: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered strobe lines up with EMIT_A/EMIT_B.
    always_comb begin
        w_valid_nxt = 1'b0;
        w_data_nxt  = r_data_out;
        unique case (w_state_nxt)
            S_EMIT_A: begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = r_pass;
            end
            S_EMIT_B: begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_filt;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_data_nxt  = r_data_out;
            end
        endcase
    end

    // Registered output strobe and sample; data holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_valid_out <= w_valid_nxt;
            r_data_out  <= w_data_nxt;
        end
    end

    // Delay line shift and pass-through latch on accept; one coefficient pair accumulated per MAC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_dly[i] <= '0;
            end
            r_pass <= '0;
            r_acc  <= '0;
            r_k    <= '0;
        end else if (w_accept) begin
            r_dly[0] <= data_in;
            for (int i = 1; i < TAPS; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
            // d[H] after the shift is the sample currently at d[H-1].
            r_pass <= r_dly[HALF_TAPS-1];
            r_acc  <= '0;
            r_k    <= '0;
        end else if (r_state == S_MAC) begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_k   <= r_k + K_W'(1);
        end
    end

endmodule

// File: tb/tb_polyphase_halfband_interpolator.sv
// tb/tb_polyphase_halfband_interpolator.sv - self-checking bench for polyphase_halfband_interpolator
module tb_polyphase_halfband_interpolator;

    localparam int H = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_in;
    logic signed [5:0] data_in;
    logic              in_ready;
    logic              valid_out;
    logic signed [5:0] data_out;

    int errors = 0;
    int checks = 0;

    int coef [0:H-1] = '{-160, 640, -2048, 9760};
    int hist [$];

    typedef struct {
        int din;
        bit use_tab;
        int exp_p;
        int exp_f;
    } vec_t;

    vec_t tab [0:25];

    polyphase_halfband_interpolator dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        hist.delete();
        for (int i = 0; i < 2*H; i++) hist.push_back(0);
    endfunction

    function automatic void model_push(int s);
        hist.push_front(s);
        void'(hist.pop_back());
    endfunction

    function automatic int model_p();
        return hist[H];
    endfunction

    function automatic int model_f();
        longint acc;
        int r;
        acc = 0;
        for (int k = 0; k < H; k++) acc += longint'(coef[k]) * longint'(hist[k] + hist[2*H-1-k]);
        acc = acc + 8192;
        r = int'(acc >>> 14);
        if (r > 31) r = 31;
        if (r < -32) r = -32;
        return r;
    endfunction

    // One accept followed by a cycle-by-cycle check of the full response window.
    task automatic send(input int s, input bit use_tab, input int tp, input int tf);
        int n;
        int mp, mf, got_p, got_f;
        n = 0;
        got_p = 0;
        got_f = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", int'(in_ready), 1);
            return;
        end
        valid_in = 1'b1;
        data_in  = 6'(s);
        model_push(s);
        mp = model_p();
        mf = model_f();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        for (int c = 1; c <= H + 3; c++) begin
            @(negedge clk);
            chk("valid_out_win", int'(valid_out), int'(c == H + 1 || c == H + 2));
            chk("in_ready_win", int'(in_ready), int'(c == H + 3));
            if (c == H + 1) got_p = int'(data_out);
            if (c == H + 2) got_f = int'(data_out);
        end
        chk("P_model", got_p, mp);
        chk("F_model", got_f, mf);
        if (use_tab) begin
            chk("P_table", got_p, tp);
            chk("F_table", got_f, tf);
        end
    endtask

    task automatic apply_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send(tab[i].din, tab[i].use_tab, tab[i].exp_p, tab[i].exp_f);
        end
    endtask

    // Cycle-level run: accepts only in idle slots (every 7 cycles); pulse mode adds a dropped request mid-busy.
    task automatic stream(input int ncyc, input bit pulse);
        bit exp_v [0:63];
        int exp_d [0:63];
        int cur;
        bit idle, want;
        for (int i = 0; i < 64; i++) begin
            exp_v[i] = 1'b0;
            exp_d[i] = 0;
        end
        cur = 0;
        for (int c = 0; c < ncyc; c++) begin
            idle = (c % 7 == 0);
            want = pulse ? (c % 7 == 0 || c % 7 == 3) : 1'b1;
            if (idle || (pulse && want)) cur = int'($urandom_range(63)) - 32;
            valid_in = want;
            data_in  = 6'(cur);
            chk("strm_in_ready", int'(in_ready), int'(idle));
            chk("strm_valid_out", int'(valid_out), int'(exp_v[c]));
            if (exp_v[c]) chk("strm_data", int'(data_out), exp_d[c]);
            if (idle && want) begin
                model_push(cur);
                exp_v[c+5] = 1'b1;
                exp_d[c+5] = model_p();
                exp_v[c+6] = 1'b1;
                exp_d[c+6] = model_f();
            end
            @(negedge clk);
        end
        valid_in = 1'b0;
    endtask

    initial begin
        int imp_f [0:7];
        int sat_in [0:7];
        imp_f  = '{0, 1, -4, 18, 18, -4, 1, 0};
        sat_in = '{-32, 31, -32, 31, 31, -32, 31, -32};
        for (int i = 0; i < 8; i++) tab[i] = '{(i == 0) ? 31 : 0, 1'b1, (i == 4) ? 31 : 0, imp_f[i]};
        for (int i = 0; i < 8; i++) tab[8+i] = '{sat_in[i], (i == 7), 31, 31};
        for (int i = 0; i < 10; i++) tab[16+i] = '{10, (i >= 7), 10, 10};

        model_clear();

        // Reset with a sample offered: nothing may be captured.
        reset    = 1'b1;
        valid_in = 1'b1;
        data_in  = 6'sd25;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_data_out", int'(data_out), 0);

        // Impulse, saturation, DC tables.
        apply_table(0, 25);

        // Randomized samples against the model.
        for (int i = 0; i < 30; i++) send(int'($urandom_range(63)) - 32, 1'b0, 0, 0);

        // Continuous valid_in, then dropped mid-busy pulses.
        stream(21, 1'b0);
        stream(21, 1'b1);
        send(7, 1'b0, 0, 0);

        // Reset two cycles after an accept aborts the computation.
        valid_in = 1'b1;
        data_in  = 6'sd20;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("abort_valid_out", int'(valid_out), 0);
            chk("abort_in_ready", int'(in_ready), 1);
        end
        chk("abort_data_out", int'(data_out), 0);
        apply_table(0, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
